std_nbdcache_vd_ctrl: RTL and testbench



---
 rtl/std_nbdcache_vd_pkg.sv | 21 ++
 rtl/std_nbdcache_vd_sweep_cnt.sv | 45 ++++
 rtl/std_nbdcache_vd_ctrl.sv | 169 ++++++++++++++++
 tb/tb_std_nbdcache_vd_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/std_nbdcache_vd_pkg.sv
// Shared types and helpers for the valid/dirty SRAM front-end controller.
// Row layout: bit 2w = valid(w), bit 2w+1 = dirty(w).
package std_nbdcache_vd_pkg;

  localparam int unsigned VD_BITS_PER_WAY = 32'd2;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    FLUSH = 2'd2
  } vd_state_e;

  function automatic int unsigned vd_valid_idx(input int unsigned w);
    return VD_BITS_PER_WAY * w;
  endfunction

  function automatic int unsigned vd_dirty_idx(input int unsigned w);
    return VD_BITS_PER_WAY * w + 32'd1;
  endfunction

endpackage

// File: rtl/std_nbdcache_vd_sweep_cnt.sv
// Loadable row counter for the init/flush sweeps; returns to 0 after NumWords-1
// so a non-power-of-two row count never reaches unused addresses.
module std_nbdcache_vd_sweep_cnt #(
  parameter int unsigned NumWords  = 256,
  parameter int unsigned AddrWidth = $clog2(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [AddrWidth-1:0] load_val_i,
  input  logic                 en_i,
  output logic [AddrWidth-1:0] cnt_o,
  output logic                 last_o
);

  localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(NumWords - 32'd1);

  logic [AddrWidth-1:0] cnt_d, cnt_q;

  assign last_o = (cnt_q == LastIdx);
  assign cnt_o  = cnt_q;

  // Next count: load wins, then increment with wrap at the last row.
  always_comb begin
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && last_o) begin
      cnt_d = {AddrWidth{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_q + AddrWidth'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= {AddrWidth{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/std_nbdcache_vd_ctrl.sv
// Valid/dirty SRAM front-end: reset sweep, client arbitration and, with
// NBDCACHE_VD_FLUSH_EN defined, the flush sweep with pending latch and done pulse.
module std_nbdcache_vd_ctrl
  import std_nbdcache_vd_pkg::*;
#(
  parameter int unsigned NumWords  = 256,
  parameter int unsigned NumWays   = 8,
  parameter int unsigned DataWidth = VD_BITS_PER_WAY * NumWays,
  parameter int unsigned AddrWidth = $clog2(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  output logic                 flush_done_o,
  output logic                 busy_o,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [DataWidth-1:0] bmask_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [DataWidth-1:0] sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  vd_state_e            state_d, state_q;
  logic                 busy_d, busy_q;
  logic                 rvalid_d, rvalid_q;
  logic                 pend_d, pend_q;
  logic                 done_d;
  logic                 gnt;
  logic                 flush_req;
  logic                 sweep;
  logic                 cnt_load, cnt_en, cnt_last;
  logic [AddrWidth-1:0] cnt;

`ifdef NBDCACHE_VD_FLUSH_EN
  logic done_q;
  assign flush_req    = flush_i;
  assign flush_done_o = done_q;
`else
  logic unused_flush;
  assign flush_req    = 1'b0;
  assign pend_q       = 1'b0;
  assign flush_done_o = 1'b0;
  assign unused_flush = ^{flush_i, pend_d, done_d};
`endif

  std_nbdcache_vd_sweep_cnt #(
    .NumWords  (NumWords),
    .AddrWidth (AddrWidth)
  ) i_sweep_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i ({AddrWidth{1'b0}}),
    .en_i       (cnt_en),
    .cnt_o      (cnt),
    .last_o     (cnt_last)
  );

  // FSM next state; a flush seen on the last INIT row still counts as pending.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    pend_d   = pend_q;
    done_d   = 1'b0;
    rvalid_d = 1'b0;
    gnt      = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      INIT: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          pend_d = 1'b0;
          if (pend_q || flush_req) begin
            state_d = FLUSH;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          pend_d = pend_q | flush_req;
        end
      end
      IDLE: begin
        if (flush_req) begin
          state_d  = FLUSH;
          busy_d   = 1'b1;
          cnt_load = 1'b1;
        end else begin
          gnt      = req_i;
          rvalid_d = req_i & ~we_i;
        end
      end
      FLUSH: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d  = INIT;
        busy_d   = 1'b1;
        cnt_load = 1'b1;
      end
    endcase
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= INIT;
      busy_q   <= 1'b1;
      rvalid_q <= 1'b0;
`ifdef NBDCACHE_VD_FLUSH_EN
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      rvalid_q <= rvalid_d;
`ifdef NBDCACHE_VD_FLUSH_EN
      pend_q   <= pend_d;
      done_q   <= done_d;
`endif
    end
  end

  assign sweep    = rst_ni & ((state_q == INIT) | (state_q == FLUSH));
  assign gnt_o    = rst_ni & gnt;
  assign busy_o   = busy_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = sram_rdata_i;

  // SRAM port mux: the sweep owns the port, otherwise a grant drives it directly.
  always_comb begin
    if (sweep) begin
      sram_req_o   = 1'b1;
      sram_we_o    = 1'b1;
      sram_addr_o  = cnt;
      sram_wdata_o = {DataWidth{1'b0}};
      sram_be_o    = {DataWidth{1'b1}};
    end else begin
      sram_req_o   = gnt_o;
      sram_we_o    = gnt_o & we_i;
      sram_addr_o  = addr_i;
      sram_wdata_o = wdata_i;
      if (gnt_o && we_i) begin
        sram_be_o = bmask_i;
      end else begin
        sram_be_o = {DataWidth{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_std_nbdcache_vd_ctrl.sv
// Directed bench for std_nbdcache_vd_ctrl: a 256-row instance and a 100-row
// instance, each with a small SRAM model; adapts to NBDCACHE_VD_FLUSH_EN.
module tb_std_nbdcache_vd_ctrl;
  import std_nbdcache_vd_pkg::*;

  logic        clk;
  logic        rst_n;
  int          n_checks;
  int          n_errors;

  logic        a_flush, a_done, a_busy, a_req, a_gnt, a_we, a_rvalid;
  logic [7:0]  a_addr;
  logic [15:0] a_wdata, a_bmask, a_rdata;
  logic        a_sram_req, a_sram_we;
  logic [7:0]  a_sram_addr;
  logic [15:0] a_sram_wdata, a_sram_be, a_sram_rdata;
  logic [15:0] mem_a [256];

  logic        b_flush, b_done, b_busy, b_req, b_gnt, b_we, b_rvalid;
  logic [6:0]  b_addr;
  logic [15:0] b_wdata, b_bmask, b_rdata;
  logic        b_sram_req, b_sram_we;
  logic [6:0]  b_sram_addr;
  logic [15:0] b_sram_wdata, b_sram_be, b_sram_rdata;
  logic [15:0] mem_b [128];

  logic [15:0] way2_valid;

  std_nbdcache_vd_ctrl #(.NumWords(256)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .flush_done_o(a_done), .busy_o(a_busy),
    .req_i(a_req), .gnt_o(a_gnt), .we_i(a_we), .addr_i(a_addr), .wdata_i(a_wdata),
    .bmask_i(a_bmask), .rvalid_o(a_rvalid), .rdata_o(a_rdata), .sram_req_o(a_sram_req),
    .sram_we_o(a_sram_we), .sram_addr_o(a_sram_addr), .sram_wdata_o(a_sram_wdata),
    .sram_be_o(a_sram_be), .sram_rdata_i(a_sram_rdata)
  );

  std_nbdcache_vd_ctrl #(.NumWords(100)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .flush_done_o(b_done), .busy_o(b_busy),
    .req_i(b_req), .gnt_o(b_gnt), .we_i(b_we), .addr_i(b_addr), .wdata_i(b_wdata),
    .bmask_i(b_bmask), .rvalid_o(b_rvalid), .rdata_o(b_rdata), .sram_req_o(b_sram_req),
    .sram_we_o(b_sram_we), .sram_addr_o(b_sram_addr), .sram_wdata_o(b_sram_wdata),
    .sram_be_o(b_sram_be), .sram_rdata_i(b_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-enable SRAM models with one cycle read latency.
  always @(posedge clk) begin
    if (a_sram_req) begin
      if (a_sram_we) mem_a[a_sram_addr] <= (mem_a[a_sram_addr] & ~a_sram_be) | (a_sram_wdata & a_sram_be);
      else a_sram_rdata <= mem_a[a_sram_addr];
    end
    if (b_sram_req) begin
      if (b_sram_we) mem_b[b_sram_addr] <= (mem_b[b_sram_addr] & ~b_sram_be) | (b_sram_wdata & b_sram_be);
      else b_sram_rdata <= mem_b[b_sram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    way2_valid = 16'h0001 << vd_valid_idx(2);
    rst_n = 1'b0; a_flush = 1'b0; a_req = 1'b1; a_we = 1'b0; a_addr = 8'd0;
    a_wdata = 16'h0000; a_bmask = 16'h0000;
    b_flush = 1'b0; b_req = 1'b0; b_we = 1'b0; b_addr = 7'd0; b_wdata = 16'h0000; b_bmask = 16'h0000;
    tick(); tick();
    check_eq("rst_a", {a_busy, a_gnt, a_rvalid, a_done, a_sram_req, a_sram_we}, 6'b100000);
    check_eq("rst_b", {b_busy, b_gnt, b_done, b_sram_req, b_sram_we}, 5'b10000);

    // Reset sweep: client requests row 0 throughout and must wait.
    rst_n = 1'b1; #1;
    for (int k = 0; k < 256; k++) begin
      check_eq("init_a", {a_busy, a_gnt, a_sram_req, a_sram_we, a_sram_addr, a_sram_wdata, a_sram_be},
               {1'b1, 1'b0, 1'b1, 1'b1, 8'(k), 16'h0000, 16'hFFFF});
      if (k < 100)
        check_eq("init_b", {b_busy, b_sram_req, b_sram_we, b_sram_addr, b_sram_be},
                 {1'b1, 1'b1, 1'b1, 7'(k), 16'hFFFF});
      else
        check_eq("idle_b", {b_busy, b_sram_req}, 2'b00);
      tick();
    end
    check_eq("init_end_a", {a_busy, a_gnt, a_sram_req, a_sram_we, a_sram_addr}, {4'b0110, 8'd0});
    tick(); a_req = 1'b0; #1;
    check_eq("rd0_zero", {a_rvalid, a_rdata}, {1'b1, 16'h0000});

    // Flush on the 100-row instance (ignored when the feature is compiled out).
    b_flush = 1'b1; #1;
    check_eq("b_flush_c", {b_busy, b_sram_req}, 2'b00);
    tick(); b_flush = 1'b0; #1;
`ifdef NBDCACHE_VD_FLUSH_EN
    for (int j = 0; j < 100; j++) begin
      check_eq("b_flush_row", {b_busy, b_done, b_sram_req, b_sram_addr}, {3'b101, 7'(j)});
      tick();
    end
    check_eq("b_flush_done", {b_busy, b_done, b_sram_req}, 3'b010);
    tick();
    check_eq("b_done_pulse", {b_busy, b_done}, 2'b00);
`else
    for (int j = 0; j < 3; j++) begin
      check_eq("b_flush_off", {b_busy, b_done, b_sram_req}, 3'b000);
      tick();
    end
`endif

    // Masked writes, then back-to-back reads.
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'd5; a_wdata = 16'h0003; a_bmask = 16'h0003; #1;
    check_eq("wr5_drv", {a_gnt, a_sram_req, a_sram_we, a_sram_addr, a_sram_wdata, a_sram_be},
             {3'b111, 8'd5, 16'h0003, 16'h0003});
    tick(); a_addr = 8'd7; a_wdata = 16'hFFFF; a_bmask = way2_valid; #1;
    check_eq("wr7_drv", {a_gnt, a_rvalid, a_sram_be}, {2'b10, 16'h0010});
    tick(); a_we = 1'b0; a_addr = 8'd5; #1;
    check_eq("rd5_drv", {a_gnt, a_rvalid, a_sram_req, a_sram_we, a_sram_addr, a_sram_be},
             {4'b1010, 8'd5, 16'h0000});
    tick(); a_addr = 8'd7; #1;
    check_eq("rd5_data", {a_gnt, a_rvalid, a_rdata}, {2'b11, 16'h0003});

    // Flush and request together, right after the row-7 read grant.
    tick(); a_flush = 1'b1; a_addr = 8'd5; #1;
    check_eq("rd7_data", {a_rvalid, a_rdata}, {1'b1, 16'h0010});
`ifdef NBDCACHE_VD_FLUSH_EN
    check_eq("flush_prio", {a_gnt, a_sram_req, a_busy}, 3'b000);
    tick();
    for (int j = 0; j < 256; j++) begin
      a_flush = (j == 50); #1;
      check_eq("flush_row", {a_busy, a_gnt, a_done, a_sram_req, a_sram_we, a_sram_addr, a_sram_be},
               {5'b10011, 8'(j), 16'hFFFF});
      tick();
    end
    a_flush = 1'b0; #1;
    check_eq("flush_done", {a_done, a_busy, a_gnt}, 3'b101);
    tick(); a_req = 1'b0; #1;
    check_eq("rd5_flushed", {a_rvalid, a_rdata, a_done, a_busy}, {1'b1, 16'h0000, 2'b00});
    a_flush = 1'b1; #1; tick(); a_flush = 1'b0;
`else
    check_eq("flush_off", {a_gnt, a_sram_req, a_done}, 3'b110);
    tick(); a_flush = 1'b0; a_req = 1'b0; #1;
    check_eq("rd5_kept", {a_rvalid, a_rdata, a_done, a_busy}, {1'b1, 16'h0003, 2'b00});
    rst_n = 1'b0; tick(); rst_n = 1'b1;
`endif

    // Abort a sweep at row 100 with reset.
    for (int j = 0; j < 100; j++) tick();
    check_eq("abort_row100", {a_busy, a_sram_req, a_sram_addr}, {2'b11, 8'd100});
    rst_n = 1'b0; tick();
    check_eq("rst2_a", {a_busy, a_gnt, a_rvalid, a_done, a_sram_req, a_sram_we}, 6'b100000);

    // Fresh init with a flush pulse at cycle 10.
    rst_n = 1'b1;
`ifdef NBDCACHE_VD_FLUSH_EN
    for (int k = 0; k < 512; k++) begin
`else
    for (int k = 0; k < 256; k++) begin
`endif
      a_flush = (k == 10); #1;
      check_eq("resweep", {a_busy, a_done, a_sram_req, a_sram_addr}, {3'b101, 8'(k % 256)});
      tick();
    end
    a_flush = 1'b0; #1;
`ifdef NBDCACHE_VD_FLUSH_EN
    check_eq("pend_done", {a_busy, a_done}, 2'b01);
`else
    check_eq("pend_off", {a_busy, a_done}, 2'b00);
`endif
    tick();
    check_eq("final_idle", {a_busy, a_done, a_sram_req}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
